// File: rtl/ber_ctrl.sv
// Measurement sequencer for a BER checker: clears it, gates symbols to it until sync,
// counts a fixed window of strobes, then snapshots its counts.
// Optional macro BER_CTRL_CONTINUOUS_EN makes DONE restart the measurement instead of idling.
module ber_ctrl #(
    parameter int RST_CYCLES   = 4,
    parameter int SYNC_TIMEOUT = 270000
) (
    input  logic        clock,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_stop,
    input  logic [32:0] i_window,
    input  logic        i_sym_valid,
    input  logic        i_ber_synced,
    input  logic [32:0] i_ber_errors,
    input  logic [32:0] i_ber_bits,
    output logic        o_ber_reset,
    output logic        o_ber_valid,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_timeout,
    output logic [32:0] o_errors,
    output logic [32:0] o_bits,
    output logic [2:0]  o_state
);

    localparam int CNT_W = 33;
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_SYNC  = 3'd2,
        S_MEAS  = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5,
        S_FAIL  = 3'd6
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               fwd;
    logic               start_acc;
    logic [CNT_W-1:0]   window_q;
    logic [CNT_W-1:0]   rst_cnt_q;
    logic [CNT_W-1:0]   sync_cnt_q;
    logic [CNT_W-1:0]   meas_cnt_q;
    logic [CNT_W-1:0]   errors_q;
    logic [CNT_W-1:0]   bits_q;
    logic               timeout_q;

    // A zero-length window would never terminate, so it is promoted to one bit.
    function automatic logic [CNT_W-1:0] sanitize_window(input logic [CNT_W-1:0] w);
        return (w == '0) ? CNT_W'(1) : w;
    endfunction

    assign start_acc = (state_q == S_IDLE) && i_start;

    always_comb begin
        state_d = state_q;
        fwd     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start)
                    state_d = S_CLR;
            end
            S_CLR: begin
                if (rst_cnt_q == RST_LAST)
                    state_d = S_SYNC;
            end
            S_SYNC: begin
                fwd = i_sym_valid && !i_ber_synced;
                // Sync on the same cycle as the last allowed strobe still counts as success.
                if (i_ber_synced)
                    state_d = S_MEAS;
                else if (fwd && (sync_cnt_q == SYNC_LAST))
                    state_d = S_FAIL;
            end
            S_MEAS: begin
                fwd = i_sym_valid && (meas_cnt_q < window_q);
                if (fwd && (meas_cnt_q == window_q - CNT_W'(1)))
                    state_d = S_DRAIN;
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE: begin
`ifdef BER_CTRL_CONTINUOUS_EN
                state_d = S_CLR;
`else
                state_d = S_IDLE;
`endif
            end
            S_FAIL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (i_stop && (state_q != S_IDLE)) begin
            fwd     = 1'b0;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            window_q   <= '0;
            rst_cnt_q  <= '0;
            sync_cnt_q <= '0;
            meas_cnt_q <= '0;
            errors_q   <= '0;
            bits_q     <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q <= state_d;

            if (start_acc) begin
                window_q  <= sanitize_window(i_window);
                timeout_q <= 1'b0;
            end else if ((state_q == S_SYNC) && (state_d == S_FAIL)) begin
                timeout_q <= 1'b1;
            end

            // Each counter is live only while its state persists, so it starts at 0 on entry.
            if ((state_q == S_CLR) && (state_d == S_CLR))
                rst_cnt_q <= rst_cnt_q + CNT_W'(1);
            else
                rst_cnt_q <= '0;

            if ((state_q == S_SYNC) && (state_d == S_SYNC))
                sync_cnt_q <= sync_cnt_q + CNT_W'(fwd);
            else
                sync_cnt_q <= '0;

            if ((state_q == S_MEAS) && (state_d == S_MEAS))
                meas_cnt_q <= meas_cnt_q + CNT_W'(fwd);
            else
                meas_cnt_q <= '0;

            if ((state_q == S_DRAIN) && (state_d == S_DONE)) begin
                errors_q <= i_ber_errors;
                bits_q   <= i_ber_bits;
            end
        end
    end

    assign o_ber_valid = fwd && !i_reset;
    assign o_ber_reset = (state_q == S_CLR) && !i_reset;
    assign o_busy      = (state_q != S_IDLE) && !i_reset;
    assign o_done      = (state_q == S_DONE) && !i_reset;
    assign o_timeout   = timeout_q;
    assign o_errors    = errors_q;
    assign o_bits      = bits_q;
    assign o_state     = state_q;

endmodule

// File: doc/ber_ctrl.md
BER_CTRL -- requirements
Module: ber_ctrl

Interface
REQ-001 Parameters SHALL be: RST_CYCLES, default 4, number of clocks the checker reset is held; SYNC_TIMEOUT, default 270000, forwarded strobes allowed in SYNC before failure.
REQ-002 clock  input  1  single clock; all logic on its rising edge.
REQ-003 i_reset  input  1  reset, synchronous and active-high.
REQ-004 i_start  input  1  one-cycle command to begin a measurement; honoured only in IDLE.
REQ-005 i_stop  input  1  abort command; honoured in every state except IDLE.
REQ-006 i_window  input  33  measurement length in bits; sampled when i_start is accepted.
REQ-007 i_sym_valid  input  1  symbol strobe from the datapath.
REQ-008 i_ber_synced  input  1  synced flag from the BER checker.
REQ-009 i_ber_errors  input  33  error count from the BER checker.
REQ-010 i_ber_bits  input  33  bit count from the BER checker.
REQ-011 o_ber_reset  output  1  synchronous reset driven to the BER checker.
REQ-012 o_ber_valid  output  1  gated strobe driven to the BER checker.
REQ-013 o_busy  output  1  high in every state except IDLE.
REQ-014 o_done  output  1  one-cycle pulse when a result snapshot is captured.
REQ-015 o_timeout  output  1  sticky flag for sync failure; cleared when i_start is accepted.
REQ-016 o_errors / o_bits  output  33 each  snapshot of the checker counts at the end of the window.
REQ-017 o_state  output  3  current state encoding.

Function
REQ-018 The state encoding SHALL be IDLE=0, CLR=1, SYNC=2, MEAS=3, DRAIN=4, DONE=5, FAIL=6.
REQ-019 IDLE SHALL go to CLR on i_start; it SHALL latch i_window, substituting 1 when i_window is 0.
REQ-020 CLR SHALL hold o_ber_reset=1 for exactly RST_CYCLES clocks and SHALL then go to SYNC; o_ber_reset SHALL be 0 in every other state.
REQ-021 In SYNC, o_ber_valid SHALL equal i_sym_valid AND NOT i_ber_synced, combinationally.
REQ-022 SYNC SHALL count forwarded strobes and SHALL go to MEAS on the clock on which i_ber_synced=1.
REQ-023 SYNC SHALL go to FAIL when the forwarded-strobe count reaches SYNC_TIMEOUT; if i_ber_synced=1 in the same cycle, MEAS SHALL win.
REQ-024 On entry to MEAS the meas counter SHALL be 0.
REQ-025 In MEAS, o_ber_valid SHALL equal i_sym_valid while meas_cnt < window.
REQ-026 MEAS SHALL increment meas_cnt on each forwarded strobe and SHALL go to DRAIN on the clock on which the window-th strobe is forwarded.
REQ-027 DRAIN SHALL last exactly 1 clock with o_ber_valid=0; it SHALL capture i_ber_errors into o_errors and i_ber_bits into o_bits at its end, then go to DONE.
REQ-028 DONE SHALL assert o_done for exactly 1 clock.
REQ-029 FAIL SHALL set o_timeout=1, leave o_errors and o_bits unchanged, and go to IDLE after 1 clock.
REQ-030 i_stop in any non-IDLE state SHALL force o_ber_valid=0 combinationally that cycle and SHALL set the next state to IDLE with no o_done and no snapshot; i_stop SHALL have priority over every other transition.
REQ-031 o_ber_valid SHALL be 0 in IDLE, CLR, DRAIN, DONE and FAIL.
REQ-032 i_start outside IDLE SHALL be ignored.
REQ-033 Counters SHALL be 33 bits wide and SHALL never wrap, because the window comparison bounds them.

Reset
REQ-034 While i_reset=1 the block SHALL set: state to IDLE; all counters to 0; o_errors=0, o_bits=0; o_timeout=0, o_done=0, o_busy=0, o_ber_valid=0, o_ber_reset=0.
REQ-035 i_reset SHALL override i_start and i_stop.
REQ-036 Reset asserted mid-measurement SHALL take effect on the next clock edge, discarding the measurement with no o_done.

Configuration
REQ-037 Macro BER_CTRL_CONTINUOUS_EN SHALL select the DONE behaviour.
REQ-038 With BER_CTRL_CONTINUOUS_EN defined, DONE SHALL go to CLR and restart with the latched window until i_stop or reset; o_busy SHALL stay 1 across restarts.
REQ-039 Without BER_CTRL_CONTINUOUS_EN, DONE SHALL go to IDLE.

Verification
REQ-040 Scenario: reset, then i_start with window=1000, checker model syncing after 300 strobes -> o_ber_reset high exactly 4 clocks; exactly 1000 strobes forwarded in MEAS; o_done once; o_bits=1000.
REQ-041 Scenario: checker model injecting 7 errors during MEAS -> o_errors=7 at o_done; values held afterwards in IDLE.
REQ-042 Scenario: i_ber_synced held 0 -> FAIL after 270000 forwarded strobes; o_timeout=1; no o_done; next i_start clears o_timeout.
REQ-043 Scenario: i_stop asserted while meas_cnt=500 -> o_ber_valid low in the same cycle; state IDLE on the next clock; o_errors and o_bits unchanged.
REQ-044 Scenario: i_window=0 -> 1 strobe forwarded; o_bits=1. Separately, i_start pulsed during MEAS -> ignored.
REQ-045 Scenario (BER_CTRL_CONTINUOUS_EN defined): window=64 -> o_done every measurement with o_busy continuously 1; i_stop returns to IDLE.
